subtree_launch_ctrl: RTL and testbench

SUBTREE_LAUNCH_CTRL -- requirements
Module: subtree_launch_ctrl

---
 rtl/subtree_launch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_subtree_launch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/subtree_launch_ctrl.sv
// Sequences the start of NUM_CHILD child blocks (serially or all at once) and
// supervises their completion with a per-wait-phase timeout.
module subtree_launch_ctrl #(
  parameter int NUM_CHILD   = 5,
  parameter int SERIAL      = 1,
  parameter int TIMEOUT_CYC = 255,
  localparam int IDX_W      = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic [NUM_CHILD-1:0] child_start_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [IDX_W-1:0]     fail_idx_o,
  output logic [NUM_CHILD-1:0] done_mask_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     k_r, k_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [NUM_CHILD-1:0] launched_r, launched_s;
  logic [NUM_CHILD-1:0] mask_r, mask_s;
  logic                 err_r, err_s;
  logic [IDX_W-1:0]     fail_idx_r, fail_idx_s;
  logic [NUM_CHILD-1:0] child_start_r, start_vec_s;
  logic                 busy_r, done_r;
  logic                 complete_s;

  function automatic logic [NUM_CHILD-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CHILD-1:0] v;
    for (int i = 0; i < NUM_CHILD; i++) begin
      v[i] = (IDX_W'(i) == idx);
    end
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CHILD-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = NUM_CHILD - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Next-state, child pointer, timeout counter and completion tracking.
  always_comb begin
    state_s    = state_r;
    k_s        = k_r;
    cnt_s      = cnt_r;
    launched_s = launched_r;
    mask_s     = mask_r;
    err_s      = err_r;
    fail_idx_s = fail_idx_r;
    complete_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_s    = ST_LAUNCH;
          k_s        = {IDX_W{1'b0}};
          cnt_s      = {CNT_W{1'b0}};
          launched_s = {NUM_CHILD{1'b0}};
          mask_s     = {NUM_CHILD{1'b0}};
          err_s      = 1'b0;
          fail_idx_s = {IDX_W{1'b0}};
        end else if (state_r == ST_DONE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_LAUNCH: begin
        // A child may already report done during its own launch cycle.
        launched_s = launched_r | child_start_r;
        mask_s     = mask_r | (child_done_i & launched_s);
        cnt_s      = {CNT_W{1'b0}};
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        mask_s = mask_r | (child_done_i & launched_r);
        if (SERIAL != 0) begin
          complete_s = mask_s[k_r];
        end else begin
          complete_s = &mask_s;
        end
        // Completion takes priority over a timeout in the same cycle.
        if (complete_s) begin
          cnt_s = {CNT_W{1'b0}};
          if ((SERIAL == 0) || (k_r == LAST_IDX)) begin
            state_s = ST_DONE;
          end else begin
            k_s     = k_r + IDX_W'(1);
            state_s = ST_LAUNCH;
          end
        end else if (cnt_r == TMO_LAST) begin
          state_s    = ST_ERR;
          err_s      = 1'b1;
          fail_idx_s = lowest_set(launched_r & ~mask_s);
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (SERIAL != 0) begin
      start_vec_s = onehot(k_s);
    end else begin
      start_vec_s = {NUM_CHILD{1'b1}};
    end
  end

  // State and output registers; outputs are decoded from the next state so they are flop-driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      k_r           <= {IDX_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      launched_r    <= {NUM_CHILD{1'b0}};
      mask_r        <= {NUM_CHILD{1'b0}};
      err_r         <= 1'b0;
      fail_idx_r    <= {IDX_W{1'b0}};
      child_start_r <= {NUM_CHILD{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      k_r           <= k_s;
      cnt_r         <= cnt_s;
      launched_r    <= launched_s;
      mask_r        <= mask_s;
      err_r         <= err_s;
      fail_idx_r    <= fail_idx_s;
      child_start_r <= (state_s == ST_LAUNCH) ? start_vec_s : {NUM_CHILD{1'b0}};
      busy_r        <= (state_s == ST_LAUNCH) || (state_s == ST_WAIT);
      done_r        <= (state_s == ST_DONE);
    end
  end

  assign child_start_o = child_start_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign err_o         = err_r;
  assign fail_idx_o    = fail_idx_r;
  assign done_mask_o   = mask_r;

endmodule

// File: tb/tb_subtree_launch_ctrl.sv
// Directed bench: one serial instance (timeout 10) and one parallel instance,
// each driven by a per-child delayed-done responder.
module tb_subtree_launch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_start = 1'b0, p_start = 1'b0;
  logic [4:0] s_child_done = 5'b0, p_child_done = 5'b0, s_stray = 5'b0;
  logic [4:0] s_child_start, p_child_start, s_mask, p_mask;
  logic       s_busy, p_busy, s_done, p_done, s_err, p_err;
  logic [2:0] s_fail, p_fail;

  subtree_launch_ctrl #(.NUM_CHILD(5), .SERIAL(1), .TIMEOUT_CYC(10)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .child_done_i(s_child_done),
    .child_start_o(s_child_start), .busy_o(s_busy), .done_o(s_done), .err_o(s_err),
    .fail_idx_o(s_fail), .done_mask_o(s_mask));

  subtree_launch_ctrl #(.NUM_CHILD(5), .SERIAL(0), .TIMEOUT_CYC(20)) dut_p (
    .clk(clk), .rst_n(rst_n), .start_i(p_start), .child_done_i(p_child_done),
    .child_start_o(p_child_start), .busy_o(p_busy), .done_o(p_done), .err_o(p_err),
    .fail_idx_o(p_fail), .done_mask_o(p_mask));

  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  int s_dly[5], s_cnt[5], p_dly[5], p_cnt[5];
  int s_order[$];
  int s_done_cnt = 0, s_done_cyc = 0, p_done_cnt = 0, p_done_cyc = 0, p_launch_cnt = 0;
  logic [4:0] s_resp, p_resp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge, run the child responders and log events.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 5; i++) begin
      s_resp[i] = 1'b0;
      if (s_child_start[i]) begin
        if (s_dly[i] == 0) s_resp[i] = 1'b1;
        else if (s_dly[i] > 0) s_cnt[i] = s_dly[i];
      end else if (s_cnt[i] > 0) begin
        s_cnt[i]--;
        if (s_cnt[i] == 0) s_resp[i] = 1'b1;
      end
      p_resp[i] = 1'b0;
      if (p_child_start[i]) begin
        if (p_dly[i] == 0) p_resp[i] = 1'b1;
        else if (p_dly[i] > 0) p_cnt[i] = p_dly[i];
      end else if (p_cnt[i] > 0) begin
        p_cnt[i]--;
        if (p_cnt[i] == 0) p_resp[i] = 1'b1;
      end
      if (s_child_start[i]) s_order.push_back(i);
    end
    s_child_done = s_resp | s_stray;
    p_child_done = p_resp;
    if (s_done) begin s_done_cnt++; s_done_cyc = cyc; end
    if (p_done) begin p_done_cnt++; p_done_cyc = cyc; end
    if (p_child_start != 5'b0) p_launch_cnt++;
  endtask

  task automatic wait_s_done(input int budget, input string tag);
    int n = 0;
    while (!s_done && n < budget) begin step(); n++; end
    chk(tag, {31'b0, s_done}, 32'd1);
  endtask

  task automatic s_begin_run();
    s_order.delete();
    s_done_cnt = 0;
    s_start = 1'b1;
    cyc = 0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++) begin s_dly[i] = 3; s_cnt[i] = 0; p_dly[i] = -1; p_cnt[i] = 0; end
    step(); step();
    chk("rst_busy", {31'b0, s_busy}, 32'd0);
    chk("rst_start", {27'b0, s_child_start}, 32'd0);
    chk("rst_done", {31'b0, s_done}, 32'd0);
    chk("rst_err", {31'b0, s_err}, 32'd0);
    chk("rst_mask", {27'b0, s_mask}, 32'd0);
    chk("rst_p_busy", {31'b0, p_busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // Serial run, every child answers 3 cycles after its start.
    s_begin_run();
    s_start = 1'b0;
    chk("ser_launch0", {27'b0, s_child_start}, 32'h01);
    chk("ser_busy_l0", {31'b0, s_busy}, 32'd1);
    step();
    chk("ser_wait0_nostart", {27'b0, s_child_start}, 32'h00);
    wait_s_done(40, "ser_done_seen");
    chk("ser_done_cyc", s_done_cyc, 21);
    chk("ser_mask", {27'b0, s_mask}, 32'h1f);
    chk("ser_err", {31'b0, s_err}, 32'd0);
    chk("ser_busy_done", {31'b0, s_busy}, 32'd0);
    chk("ser_order_len", s_order.size(), 5);
    for (int i = 0; i < 5; i++) chk("ser_order", s_order[i], i);
    step();
    chk("ser_idle_done", {31'b0, s_done}, 32'd0);
    chk("ser_idle_mask", {27'b0, s_mask}, 32'h1f);
    chk("ser_done_once", s_done_cnt, 1);

    // Parallel run, dones at 2,7,4,1,9 cycles after launch.
    p_dly[0] = 2; p_dly[1] = 7; p_dly[2] = 4; p_dly[3] = 1; p_dly[4] = 9;
    p_start = 1'b1; cyc = 0; p_launch_cnt = 0; p_done_cnt = 0;
    step();
    p_start = 1'b0;
    chk("par_launch", {27'b0, p_child_start}, 32'h1f);
    chk("par_busy", {31'b0, p_busy}, 32'd1);
    step();
    chk("par_wait_nostart", {27'b0, p_child_start}, 32'h00);
    while (cyc < 9) step();
    chk("par_mask_c9", {27'b0, p_mask}, 32'h0f);
    while (!p_done && cyc < 30) step();
    chk("par_done_cyc", p_done_cyc, 11);
    chk("par_mask", {27'b0, p_mask}, 32'h1f);
    chk("par_err", {31'b0, p_err}, 32'd0);
    chk("par_launch_cnt", p_launch_cnt, 1);
    step();
    chk("par_done_once", p_done_cnt, 1);

    // Serial timeout: child0 answers on the last allowed cycle, child1 at once, child2 never.
    s_dly[0] = 10; s_dly[1] = 0; s_dly[2] = -1;
    s_begin_run();
    s_start = 1'b0;
    while (cyc < 12) step();
    chk("tmo_edge_launch1", {27'b0, s_child_start}, 32'h02);
    chk("tmo_edge_noerr", {31'b0, s_err}, 32'd0);
    while (cyc < 14) step();
    chk("tmo_zero_cyc_launch2", {27'b0, s_child_start}, 32'h04);
    while (cyc < 24) step();
    chk("tmo_last_wait_err", {31'b0, s_err}, 32'd0);
    chk("tmo_last_wait_busy", {31'b0, s_busy}, 32'd1);
    step();
    chk("tmo_err", {31'b0, s_err}, 32'd1);
    chk("tmo_fail_idx", {29'b0, s_fail}, 32'd2);
    chk("tmo_mask", {27'b0, s_mask}, 32'h03);
    chk("tmo_busy", {31'b0, s_busy}, 32'd0);
    repeat (3) step();
    chk("tmo_err_sticky", {31'b0, s_err}, 32'd1);
    chk("tmo_no_child3", s_order.size(), 3);
    chk("tmo_no_done", s_done_cnt, 0);

    // Restart from ERR, then reset during the wait on child 3.
    for (int i = 0; i < 5; i++) s_dly[i] = 3;
    s_begin_run();
    s_start = 1'b0;
    chk("rerun_err_clr", {31'b0, s_err}, 32'd0);
    chk("rerun_fail_clr", {29'b0, s_fail}, 32'd0);
    chk("rerun_mask_clr", {27'b0, s_mask}, 32'd0);
    chk("rerun_launch0", {27'b0, s_child_start}, 32'h01);
    while (cyc < 14) step();
    chk("rst_mid_mask_before", {27'b0, s_mask}, 32'h07);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, s_busy}, 32'd0);
    chk("rst_mid_start", {27'b0, s_child_start}, 32'd0);
    chk("rst_mid_mask", {27'b0, s_mask}, 32'd0);
    chk("rst_mid_err", {31'b0, s_err}, 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("rst_late_done_mask", {27'b0, s_mask}, 32'd0);
    chk("rst_late_busy", {31'b0, s_busy}, 32'd0);
    chk("rst_no_done", s_done_cnt, 0);

    // start_i held high, stray dones on unlaunched children, back-to-back runs.
    s_stray = 5'b11000;
    s_begin_run();
    chk("hold_launch0", {27'b0, s_child_start}, 32'h01);
    step();
    chk("hold_no_restart", {27'b0, s_child_start}, 32'h00);
    step(); step();
    s_stray = 5'b00000;
    step();
    chk("hold_stray_mask", {27'b0, s_mask}, 32'h01);
    chk("hold_launch1", {27'b0, s_child_start}, 32'h02);
    wait_s_done(40, "hold_done_seen");
    chk("hold_done_cyc", s_done_cyc, 21);
    chk("hold_mask", {27'b0, s_mask}, 32'h1f);
    step();
    chk("b2b_launch0", {27'b0, s_child_start}, 32'h01);
    chk("b2b_busy", {31'b0, s_busy}, 32'd1);
    chk("b2b_mask_clr", {27'b0, s_mask}, 32'd0);
    chk("b2b_done_low", {31'b0, s_done}, 32'd0);
    s_start = 1'b0;
    wait_s_done(40, "b2b_done_seen");
    chk("b2b_done_cyc", s_done_cyc, 42);
    chk("b2b_done_cnt", s_done_cnt, 2);
    chk("b2b_order_len", s_order.size(), 10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
